// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the byte-level UART transmit path.
//   * default frame / divisor widths
//   * FSM state encoding of uart_tx_core (IDLE..STOP)
//   * select codes of the protocol layer's byte mux (FIFO / address / payload /
//     end-frame), so that the producer and consumer agree on one encoding
//   * frame_parity(): parity helper used when UART_TX_PARITY_EN is defined
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default geometry.
  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  // Transmitter state encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  // Protocol-layer byte mux select codes.
  localparam logic [1:0] SEL_FIFO      = 2'd0;
  localparam logic [1:0] SEL_ADDR      = 2'd1;
  localparam logic [1:0] SEL_PAYLOAD   = 2'd2;
  localparam logic [1:0] SEL_END_FRAME = 2'd3;

  typedef enum logic [1:0] {
    MUX_FIFO      = SEL_FIFO,
    MUX_ADDR      = SEL_ADDR,
    MUX_PAYLOAD   = SEL_PAYLOAD,
    MUX_END_FRAME = SEL_END_FRAME
  } prot_sel_e;

  // Parity of a byte (zero-extended to 32 bits, which leaves the XOR
  // unchanged); odd = 1 flips the result so the total count of ones is odd.
  function automatic logic frame_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// -----------------------------------------------------------------------------
// uart_tx_core_if
// Handshake between the send-protocol state machine (master) and the UART
// transmitter core (slave).
//   PROT_STM_ctrl_empty       master -> slave  no byte available
//   PROT_STM_data_byte        master -> slave  muxed byte, first-word-fall-through
//   UART_core_ctrl_FIFO_r_en  slave  -> master one-cycle pop strobe
// -----------------------------------------------------------------------------
interface uart_tx_core_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              PROT_STM_ctrl_empty;
  logic [DATA_W-1:0] PROT_STM_data_byte;
  logic              UART_core_ctrl_FIFO_r_en;

  // Protocol layer: offers bytes, consumes the pop strobe.
  modport master (
    output PROT_STM_ctrl_empty,
    output PROT_STM_data_byte,
    input  UART_core_ctrl_FIFO_r_en
  );

  // Transmitter core: watches empty, pops one byte per frame.
  modport slave (
    input  PROT_STM_ctrl_empty,
    input  PROT_STM_data_byte,
    output UART_core_ctrl_FIFO_r_en
  );

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts glb_clk cycles from 0 up to div and flags the last
// cycle of every bit period with bit_tick, so one period is div + 1 cycles
// (div = 0 ticks every cycle).
// Ports:
//   glb_clk   in   system clock
//   glb_rstn  in   asynchronous active-low reset
//   clear     in   restart the period (asserted while the core is in LOAD)
//   div       in   bit period minus one (already latched by the core)
//   bit_tick  out  high in the final cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             glb_clk,
  input  logic             glb_rstn,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_r;

  // Decoded from the registered count and the registered divisor, so no input
  // of the core reaches this strobe combinationally.
  assign bit_tick = (cnt_r == div);

  // Period counter: restart on clear or at the end of each period.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (bit_tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Byte-level UART transmitter. Pulls one byte from the protocol layer with a
// single-cycle pop strobe and sends it LSB first as start / data / [parity] /
// stop at a programmable bit period.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined     -> Cfg_ctrl_parity_en / Cfg_ctrl_parity_odd ports and the
//                  PARITY state exist; parity appended when enabled.
//   not defined -> frame is always start + DATA_W + stop.
//
// Ports:
//   glb_clk              in   system clock, rising edge
//   glb_rstn             in   asynchronous active-low reset
//   Cfg_ctrl_Tx_en       in   allows new frames to start
//   Cfg_ctrl_baud_div    in   bit period minus one, latched at LOAD
//   Cfg_ctrl_parity_en   in   append parity (UART_TX_PARITY_EN only)
//   Cfg_ctrl_parity_odd  in   1 = odd, 0 = even (UART_TX_PARITY_EN only)
//   prot_if              slave side of uart_tx_core_if (empty, byte, r_en)
//   UART_core_ctrl_busy  out  high whenever the FSM is not IDLE
//   UART_tx              out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic             glb_clk,
  input  logic             glb_rstn,
  input  logic             Cfg_ctrl_Tx_en,
  input  logic [DIV_W-1:0] Cfg_ctrl_baud_div,
`ifdef UART_TX_PARITY_EN
  input  logic             Cfg_ctrl_parity_en,
  input  logic             Cfg_ctrl_parity_odd,
`endif
  uart_tx_core_if.slave    prot_if,
  output logic             UART_core_ctrl_busy,
  output logic             UART_tx
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  tx_state_e             state_r;
  logic [DATA_W-1:0]     shift_r;
  logic [DIV_W-1:0]      div_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic                  ren_r;
  logic                  busy_r;
  logic                  tx_r;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_r;
  logic                  par_bit_r;
`endif

  logic                  load_s;
  logic                  bit_tick_s;

  // The baud counter restarts at the closing edge of LOAD, together with the
  // divisor latch, so the start bit always gets a full period at the new rate.
  assign load_s = (state_r == S_LOAD);

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .glb_clk  (glb_clk),
    .glb_rstn (glb_rstn),
    .clear    (load_s),
    .div      (div_r),
    .bit_tick (bit_tick_s)
  );

  assign prot_if.UART_core_ctrl_FIFO_r_en = ren_r;
  assign UART_core_ctrl_busy              = busy_r;
  assign UART_tx                          = tx_r;

  // Transmit FSM; every output is a register updated alongside the state.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state_r   <= S_IDLE;
      shift_r   <= '0;
      div_r     <= '0;
      bit_cnt_r <= '0;
      ren_r     <= 1'b0;
      busy_r    <= 1'b0;
      tx_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
`endif
    end else begin
      // Pop strobe lasts exactly the LOAD cycle.
      ren_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // Tx_en only gates the start of a frame; empty is only looked at here.
          if (Cfg_ctrl_Tx_en && !prot_if.PROT_STM_ctrl_empty) begin
            state_r <= S_LOAD;
            ren_r   <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_LOAD: begin
          // Byte and all configuration are frozen for the whole frame here.
          shift_r   <= prot_if.PROT_STM_data_byte;
          div_r     <= Cfg_ctrl_baud_div;
          bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
          par_en_r  <= Cfg_ctrl_parity_en;
          par_bit_r <= frame_parity(32'(prot_if.PROT_STM_data_byte), Cfg_ctrl_parity_odd);
`endif
          tx_r      <= 1'b0;
          state_r   <= S_START;
        end

        S_START: begin
          if (bit_tick_s) begin
            tx_r    <= shift_r[0];
            state_r <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_tick_s) begin
            if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_r) begin
                tx_r    <= par_bit_r;
                state_r <= S_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= S_STOP;
              end
`else
              tx_r    <= 1'b1;
              state_r <= S_STOP;
`endif
            end else begin
              // Drive the next bit directly from shift_r[1] so the line
              // changes on the same edge the register shifts.
              tx_r      <= shift_r[1];
              shift_r   <= shift_r >> 1;
              bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_tick_s) begin
            tx_r    <= 1'b1;
            state_r <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (bit_tick_s) begin
            busy_r  <= 1'b0;
            tx_r    <= 1'b1;
            state_r <= S_IDLE;
          end
        end

        default: begin
          // Unreachable encodings recover to a quiet idle line.
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Directed stimulus feeds a small byte FIFO model and pushes one expected-frame
// record per byte that should be sent. A single negedge monitor pops a record
// on every pop strobe and compares the line cycle by cycle against the frame
// rebuilt from that record.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         par_en;
    bit         par_bit;
    int         ren_cyc;
    bit         abort_ok;
  } exp_t;

  logic             glb_clk = 1'b0;
  logic             glb_rstn = 1'b0;
  logic             tx_en = 1'b0;
  logic [DIV_W-1:0] baud_div = 16'd0;
`ifdef UART_TX_PARITY_EN
  logic             par_en = 1'b0;
  logic             par_odd = 1'b0;
`endif
  logic             busy;
  logic             tx;

  uart_tx_core_if #(.DATA_W(DATA_W)) prot_if ();

  uart_tx_core #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) dut (
    .glb_clk             (glb_clk),
    .glb_rstn            (glb_rstn),
    .Cfg_ctrl_Tx_en      (tx_en),
    .Cfg_ctrl_baud_div   (baud_div),
`ifdef UART_TX_PARITY_EN
    .Cfg_ctrl_parity_en  (par_en),
    .Cfg_ctrl_parity_odd (par_odd),
`endif
    .prot_if             (prot_if),
    .UART_core_ctrl_busy (busy),
    .UART_tx             (tx)
  );

  always #5 glb_clk = ~glb_clk;

  int cyc = 0;
  always @(posedge glb_clk) cyc <= cyc + 1;

  // Source FIFO (stimulus writes, monitor reads) and scoreboard.
  logic [7:0] src_mem [0:31];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  exp_t       exp_mem [0:31];
  int         exp_wr = 0;
  int         exp_rd = 0;
  bit         final_req = 1'b0;

  // Monitor-owned state.
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   in_frame = 1'b0;
  bit   pop_pending = 1'b0;
  bit   final_done = 1'b0;
  exp_t cur;
  int   bit_idx;
  int   cyc_in_bit;
  int   nbits;
  int   fr_no = 0;
  logic exp_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor and FIFO model.
  always @(negedge glb_clk) begin
    if (!glb_rstn) begin
      chk("reset_line", {30'd0, busy, tx}, 32'd1);
      chk("reset_ren", {31'd0, prot_if.UART_core_ctrl_FIFO_r_en}, 32'd0);
      if (in_frame) begin
        chk("abort_expected", {31'd0, cur.abort_ok}, 32'd1);
        in_frame = 1'b0;
      end
    end else if (prot_if.UART_core_ctrl_FIFO_r_en) begin
      chk("ren_while_empty", {31'd0, prot_if.PROT_STM_ctrl_empty}, 32'd0);
      chk("ren_mid_frame", {31'd0, in_frame}, 32'd0);
      chk("ren_expected", {31'd0, exp_rd != exp_wr}, 32'd1);
      if (exp_rd != exp_wr) begin
        cur = exp_mem[exp_rd];
        exp_rd++;
        fr_no++;
        if (cur.ren_cyc >= 0) chk($sformatf("frame%0d_ren_cycle", fr_no), cyc, cur.ren_cyc);
        chk($sformatf("frame%0d_load_line", fr_no), {30'd0, busy, tx}, 32'd3);
        in_frame   = 1'b1;
        bit_idx    = 0;
        cyc_in_bit = 0;
        nbits      = 10 + (cur.par_en ? 1 : 0);
      end
    end else if (in_frame) begin
      if (bit_idx < nbits) begin
        if (bit_idx == 0)                exp_bit = 1'b0;
        else if (bit_idx <= 8)           exp_bit = cur.data[bit_idx-1];
        else if (bit_idx == nbits - 1)   exp_bit = 1'b1;
        else                             exp_bit = cur.par_bit;
        chk($sformatf("frame%0d_bit%0d", fr_no, bit_idx), {30'd0, busy, tx}, {30'd0, 1'b1, exp_bit});
        if (cyc_in_bit == cur.div) begin
          cyc_in_bit = 0;
          bit_idx++;
        end else begin
          cyc_in_bit++;
        end
      end else begin
        chk($sformatf("frame%0d_end_idle", fr_no), {30'd0, busy, tx}, 32'd1);
        chk($sformatf("frame%0d_completed", fr_no), {31'd0, cur.abort_ok}, 32'd0);
        in_frame = 1'b0;
      end
    end else begin
      chk("idle_line", {30'd0, busy, tx}, 32'd1);
    end

    if (final_req && !final_done) begin
      chk("pending_frames", exp_wr - exp_rd, 32'd0);
      final_done = 1'b1;
    end

    // FIFO model: the byte leaves one cycle after the LOAD that latched it.
    if (pop_pending) rd_ptr++;
    pop_pending = glb_rstn && prot_if.UART_core_ctrl_FIFO_r_en;
    prot_if.PROT_STM_ctrl_empty = (rd_ptr == wr_ptr);
    prot_if.PROT_STM_data_byte  = (rd_ptr == wr_ptr) ? 8'h00 : src_mem[rd_ptr % 32];
  end

  task automatic push_byte(input logic [7:0] b);
    src_mem[wr_ptr % 32] = b;
    wr_ptr++;
  endtask

  task automatic push_exp(input logic [7:0] b, input int d, input bit pe, input bit pb,
                          input int rc, input bit ab);
    exp_t e;
    e.data = b; e.div = d; e.par_en = pe; e.par_bit = pb; e.ren_cyc = rc; e.abort_ok = ab;
    exp_mem[exp_wr % 32] = e;
    exp_wr++;
  endtask

  task automatic step();
    @(posedge glb_clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_rd != exp_wr || in_frame) && n < max_cyc) begin
      @(posedge glb_clk);
      n++;
    end
    #1;
  endtask

  int c0;

  initial begin
    // Reset released with a byte available but Tx_en low: 100 quiet cycles.
    baud_div = 16'd3;
    push_byte(8'hA5);
    repeat (3) step();
    glb_rstn = 1'b1;
    repeat (100) step();

    // div = 3, 0xA5, no parity: enable at c0 -> r_en at c0+1, start at c0+2.
    c0 = cyc;
    push_exp(8'hA5, 3, 1'b0, 1'b0, c0 + 1, 1'b0);
    tx_en = 1'b1;
    wait_drain(200);
    repeat (3) step();

`ifdef UART_TX_PARITY_EN
    // 0xA5 has four ones: even parity 0, odd parity 1; 44-cycle frames.
    par_en  = 1'b1;
    par_odd = 1'b0;
    c0 = cyc;
    push_exp(8'hA5, 3, 1'b1, 1'b0, c0 + 1, 1'b0);
    push_byte(8'hA5);
    wait_drain(200);
    repeat (3) step();
    par_odd = 1'b1;
    c0 = cyc;
    push_exp(8'hA5, 3, 1'b1, 1'b1, c0 + 1, 1'b0);
    push_byte(8'hA5);
    wait_drain(200);
    par_en = 1'b0;
    repeat (3) step();
`endif

    // Three queued bytes at div = 0: pops exactly 12 cycles apart.
    baud_div = 16'd0;
    c0 = cyc;
    push_exp(8'h01, 0, 1'b0, 1'b0, c0 + 1,  1'b0);
    push_exp(8'hFE, 0, 1'b0, 1'b0, c0 + 13, 1'b0);
    push_exp(8'h6C, 0, 1'b0, 1'b0, c0 + 25, 1'b0);
    push_byte(8'h01);
    push_byte(8'hFE);
    push_byte(8'h6C);
    wait_drain(200);
    repeat (3) step();

    // div = 3 frame; mid-DATA drop Tx_en and change div to 7. The frame keeps
    // 4 cycles per bit and the second queued byte is never popped.
    baud_div = 16'd3;
    c0 = cyc;
    push_exp(8'h3C, 3, 1'b0, 1'b0, c0 + 1, 1'b0);
    push_byte(8'h3C);
    push_byte(8'h99);
    repeat (14) step();
    tx_en    = 1'b0;
    baud_div = 16'd7;
    wait_drain(200);
    repeat (40) step();

    // Reset in the middle of DATA, then a clean frame right after release.
    baud_div = 16'd3;
    c0 = cyc;
    push_exp(8'h99, 3, 1'b0, 1'b0, c0 + 1, 1'b1);
    tx_en = 1'b1;
    repeat (14) step();
    glb_rstn = 1'b0;
    repeat (2) step();
    push_byte(8'h5A);
    step();
    push_exp(8'h5A, 3, 1'b0, 1'b0, cyc + 1, 1'b0);
    glb_rstn = 1'b1;
    wait_drain(200);
    repeat (5) step();

    final_req = 1'b1;
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
